// File: rtl/mac_kbd_host.sv
// Mac keyboard-link initiator: runs Test, Model, then a continuous Inquiry poll
// over the byte/strobe link and decodes replies (including 0x79 keypad prefix) into key events.
module mac_kbd_host #(
  parameter logic [22:0] REPLY_TIMEOUT = 23'h401000,
  parameter logic [15:0] POLL_GAP      = 16'h0100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       enable,
  output logic [7:0] data_out,
  output logic       strobe_out,
  input  logic [7:0] data_in,
  input  logic       strobe_in,
  output logic       key_valid,
  output logic [6:0] key_code,
  output logic       key_up,
  output logic       keypad,
  output logic [7:0] model,
  output logic       model_valid,
  output logic       error,
  output logic       busy
);

  localparam int unsigned TMO_W = 23;
  localparam int unsigned GAP_W = 16;

  localparam logic [7:0] CMD_TEST  = 8'h36;
  localparam logic [7:0] CMD_MODEL = 8'h16;
  localparam logic [7:0] CMD_INQ   = 8'h10;
  localparam logic [7:0] CMD_INST  = 8'h14;
  localparam logic [7:0] RSP_ACK   = 8'h7D;
  localparam logic [7:0] RSP_NULL  = 8'h7B;
  localparam logic [7:0] RSP_KPAD  = 8'h79;

  typedef enum logic [3:0] {
    IDLE, SEND_TEST, WAIT_TEST, SEND_MODEL, WAIT_MODEL,
    GAP, SEND_INQ, WAIT_INQ, SEND_INST, WAIT_INST
  } state_t;

  state_t             state, state_n;
  logic [TMO_W-1:0]   to_cnt, to_n, to_inc_c;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic               kp, kp_n;
  logic               resync, resync_n;
  logic [7:0]         data_n, model_n;
  logic               strobe_n, kv_n, up_n, kpad_n, mv_n, err_n;
  logic [6:0]         code_n;
  logic               to_hit_c, gap_done_c, timeout_c;

  assign to_hit_c   = (to_cnt == REPLY_TIMEOUT - TMO_W'(1));
  assign to_inc_c   = (to_cnt == {TMO_W{1'b1}}) ? to_cnt : to_cnt + TMO_W'(1);
  // POLL_GAP of zero still spends one cycle in GAP
  assign gap_done_c = ({1'b0, gap_cnt} + 17'(1)) >= {1'b0, POLL_GAP};

  always_comb begin
    state_n   = state;
    data_n    = data_out;
    strobe_n  = 1'b0;
    kv_n      = 1'b0;
    code_n    = key_code;
    up_n      = key_up;
    kpad_n    = keypad;
    model_n   = model;
    mv_n      = model_valid;
    err_n     = 1'b0;
    to_n      = to_cnt;
    gap_n     = gap_cnt;
    kp_n      = kp;
    resync_n  = resync;
    timeout_c = 1'b0;

    case (state)
      IDLE: if (enable) state_n = SEND_TEST;

      SEND_TEST: begin
        data_n   = CMD_TEST;
        strobe_n = 1'b1;
        to_n     = '0;
        resync_n = 1'b0;
        kp_n     = 1'b0;
        state_n  = WAIT_TEST;
      end

      WAIT_TEST: begin
        to_n = to_inc_c;
        if (strobe_in) begin
          if (data_in == RSP_ACK) begin
            state_n = SEND_MODEL;
          end else begin
            err_n    = 1'b1;
            resync_n = 1'b1;
            gap_n    = '0;
            state_n  = GAP;
          end
        end else begin
          timeout_c = to_hit_c;
        end
      end

      SEND_MODEL: begin
        data_n   = CMD_MODEL;
        strobe_n = 1'b1;
        to_n     = '0;
        state_n  = WAIT_MODEL;
      end

      WAIT_MODEL: begin
        to_n = to_inc_c;
        if (strobe_in) begin
          model_n = data_in;
          mv_n    = 1'b1;
          gap_n   = '0;
          state_n = GAP;
        end else begin
          timeout_c = to_hit_c;
        end
      end

      GAP: begin
        if (gap_done_c) begin
          if (!enable)                    state_n = IDLE;
          else if (resync || !model_valid) state_n = SEND_TEST;
          else                            state_n = SEND_INQ;
        end else begin
          gap_n = gap_cnt + GAP_W'(1);
        end
      end

      SEND_INQ: begin
        data_n   = CMD_INQ;
        strobe_n = 1'b1;
        to_n     = '0;
        state_n  = WAIT_INQ;
      end

      WAIT_INQ: begin
        to_n = to_inc_c;
        if (strobe_in) begin
          gap_n = '0;
          if (data_in == RSP_NULL) begin
            state_n = GAP;
          end else if (data_in == RSP_KPAD) begin
            kp_n    = 1'b1;
            state_n = SEND_INST;
          end else begin
            kv_n    = 1'b1;
            code_n  = data_in[6:0];
            up_n    = data_in[7];
            kpad_n  = 1'b0;
            state_n = GAP;
          end
        end else begin
          timeout_c = to_hit_c;
        end
      end

      SEND_INST: begin
        data_n   = CMD_INST;
        strobe_n = 1'b1;
        to_n     = '0;
        state_n  = WAIT_INST;
      end

      WAIT_INST: begin
        to_n = to_inc_c;
        if (strobe_in) begin
          gap_n = '0;
          if (data_in == RSP_NULL) begin
            kp_n    = 1'b0;
            state_n = GAP;
          end else if (data_in == RSP_KPAD) begin
            state_n = SEND_INST;
          end else begin
            kv_n    = 1'b1;
            code_n  = data_in[6:0];
            up_n    = data_in[7];
            kpad_n  = kp;
            kp_n    = 1'b0;
            state_n = GAP;
          end
        end else begin
          timeout_c = to_hit_c;
        end
      end

      default: state_n = IDLE;
    endcase

    // Silent keyboard: flag it and resynchronise from Test
    if (timeout_c) begin
      err_n   = 1'b1;
      mv_n    = 1'b0;
      kp_n    = 1'b0;
      state_n = enable ? SEND_TEST : IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      data_out    <= 8'h00;
      strobe_out  <= 1'b0;
      key_valid   <= 1'b0;
      key_code    <= 7'h00;
      key_up      <= 1'b0;
      keypad      <= 1'b0;
      model       <= 8'h00;
      model_valid <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      kp          <= 1'b0;
      resync      <= 1'b0;
    end else if (ce) begin
      state       <= state_n;
      data_out    <= data_n;
      strobe_out  <= strobe_n;
      key_valid   <= kv_n;
      key_code    <= code_n;
      key_up      <= up_n;
      keypad      <= kpad_n;
      model       <= model_n;
      model_valid <= mv_n;
      error       <= err_n;
      busy        <= (state_n != IDLE);
      to_cnt      <= to_n;
      gap_cnt     <= gap_n;
      kp          <= kp_n;
      resync      <= resync_n;
    end
  end

endmodule

// File: tb/tb_mac_kbd_host.sv
// Directed bench for mac_kbd_host: a scripted keyboard responder answers each
// command and the bench checks commands, latencies, key events and errors.
module tb_mac_kbd_host;

  localparam int unsigned TMO = 64;
  localparam int unsigned GAP = 8;

  logic       clk = 1'b0;
  logic       reset, ce, enable, strobe_in;
  logic [7:0] data_in;
  logic [7:0] data_out, model;
  logic       strobe_out, key_valid, key_up, keypad, model_valid, error, busy;
  logic [6:0] key_code;

  int n_checks = 0;
  int n_fail   = 0;
  int kv_cnt   = 0;
  int err_cnt  = 0;
  logic [6:0] last_code = '0;
  logic       last_up = 1'b0, last_kp = 1'b0;

  mac_kbd_host #(.REPLY_TIMEOUT(23'(TMO)), .POLL_GAP(16'(GAP))) dut (
    .clk(clk), .reset(reset), .ce(ce), .enable(enable),
    .data_out(data_out), .strobe_out(strobe_out),
    .data_in(data_in), .strobe_in(strobe_in),
    .key_valid(key_valid), .key_code(key_code), .key_up(key_up), .keypad(keypad),
    .model(model), .model_valid(model_valid), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Event recorder
  always @(negedge clk) begin
    if (key_valid) begin
      kv_cnt++;
      last_code = key_code;
      last_up   = key_up;
      last_kp   = keypad;
    end
    if (error) err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the next command strobe; lat counts negedges until seen
  task automatic wait_cmd(output logic [7:0] b, output int lat, output logic ok);
    b = 8'h00; lat = 0; ok = 1'b0;
    while (lat < int'(4 * TMO) && !ok) begin
      @(negedge clk);
      lat++;
      if (strobe_out) begin
        ok = 1'b1;
        b  = data_out;
      end
    end
  endtask

  task automatic expect_cmd(input string tag, input logic [7:0] exp, output int lat);
    logic [7:0] b;
    logic ok;
    wait_cmd(b, lat, ok);
    check_eq({tag, "_seen"}, 32'(ok), 32'd1);
    check_eq({tag, "_byte"}, 32'(b), 32'(exp));
  endtask

  // Reply after d further cycles; returns on the negedge after the reply edge
  task automatic send_reply(input logic [7:0] b, input int d);
    repeat (d) @(negedge clk);
    data_in   = b;
    strobe_in = 1'b1;
    @(negedge clk);
    strobe_in = 1'b0;
  endtask

  task automatic check_gap_lat(input string tag, input int lat);
    check_eq(tag, 32'(lat >= int'(GAP) && lat <= int'(GAP) + 2), 32'd1);
  endtask

  // From a just-seen Test command through to the first Inquiry
  task automatic bring_up_after_test(input string tag);
    int lat;
    send_reply(8'h7D, 10);
    expect_cmd({tag, "_model"}, 8'h16, lat);
    send_reply(8'h03, 10);
    expect_cmd({tag, "_inq"}, 8'h10, lat);
    check_gap_lat({tag, "_inq_gap"}, lat);
    check_eq({tag, "_model_val"}, 32'(model), 32'h03);
    check_eq({tag, "_model_valid"}, 32'(model_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_cmd"}, 32'({strobe_out, data_out}), 32'd0);
    check_eq({tag, "_key"}, 32'({key_valid, key_code, key_up, keypad}), 32'd0);
    check_eq({tag, "_model"}, 32'({model_valid, model}), 32'd0);
    check_eq({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b1; ce = 1'b1; enable = 1'b0; strobe_in = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_no_enable", 32'(busy), 32'd0);
    enable = 1'b1;

    expect_cmd("bu0_test", 8'h36, lat);
    bring_up_after_test("bu0");

    send_reply(8'h1B, 5);
    expect_cmd("k1_next", 8'h10, lat);
    check_gap_lat("k1_gap", lat);
    check_eq("k1_cnt", 32'(kv_cnt), 32'd1);
    check_eq("k1_ev", 32'({last_code, last_up, last_kp}), 32'({7'h1B, 1'b0, 1'b0}));

    send_reply(8'h9B, 3);
    expect_cmd("k2_next", 8'h10, lat);
    check_eq("k2_cnt", 32'(kv_cnt), 32'd2);
    check_eq("k2_ev", 32'({last_code, last_up, last_kp}), 32'({7'h1B, 1'b1, 1'b0}));

    send_reply(8'h79, 4);
    expect_cmd("kp_inst", 8'h14, lat);
    check_eq("kp_no_gap", 32'(lat), 32'd1);
    check_eq("kp_prefix_no_ev", 32'(kv_cnt), 32'd2);
    send_reply(8'h2D, 4);
    expect_cmd("kp_next", 8'h10, lat);
    check_eq("kp_cnt", 32'(kv_cnt), 32'd3);
    check_eq("kp_ev", 32'({last_code, last_up, last_kp}), 32'({7'h2D, 1'b0, 1'b1}));

    // Silent responder during WAIT_INQ
    lat = 0;
    while (lat < int'(4 * TMO) && !error) begin
      @(negedge clk);
      lat++;
    end
    check_eq("to_latency", 32'(lat), 32'(TMO));
    check_eq("to_model_valid", 32'(model_valid), 32'd0);
    expect_cmd("to_resync", 8'h36, lat);
    check_eq("to_resync_lat", 32'(lat), 32'd1);

    // Bad Test acknowledge
    send_reply(8'h00, 6);
    expect_cmd("bad_ack_resend", 8'h36, lat);
    check_gap_lat("bad_ack_gap", lat);
    check_eq("bad_ack_err", 32'(err_cnt), 32'd2);
    bring_up_after_test("bu1");

    // Reply lands in the expiry cycle, and is a null reply
    send_reply(8'h7B, int'(TMO) - 1);
    expect_cmd("exp_next", 8'h10, lat);
    check_gap_lat("exp_gap", lat);
    check_eq("exp_no_err", 32'(err_cnt), 32'd2);
    check_eq("null_no_ev", 32'(kv_cnt), 32'd3);

    // Reset while waiting on the keypad follow-up
    send_reply(8'h79, 2);
    expect_cmd("rst_inst", 8'h14, lat);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst1");
    data_in = 8'h2D; strobe_in = 1'b1;
    repeat (4) @(negedge clk);
    strobe_in = 1'b0;
    check_eq("rst1_no_ev", 32'(kv_cnt), 32'd3);
    reset = 1'b0;

    expect_cmd("bu2_test", 8'h36, lat);
    bring_up_after_test("bu2");

    // Drop enable mid-WAIT_INQ: reply still decoded, then idle
    repeat (2) @(negedge clk);
    enable = 1'b0;
    send_reply(8'h22, 3);
    lat = 0;
    while (lat < int'(4 * GAP) && busy) begin
      @(negedge clk);
      lat++;
    end
    check_eq("en_busy_low", 32'(busy), 32'd0);
    check_eq("en_ev", 32'({kv_cnt, last_code, last_up, last_kp}),
             32'({25'd4, 7'h22, 1'b0, 1'b0}));
    check_eq("en_model_kept", 32'(model_valid), 32'd1);
    begin
      logic [7:0] b;
      logic ok;
      wait_cmd(b, lat, ok);
      check_eq("en_no_cmd", 32'(ok), 32'd0);
    end
    check_eq("total_err", 32'(err_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
